// File: rtl/newbyte_pkg.sv
// Shared widths, FSM states and target encodings for the newbyte lane sequencer.
package newbyte_pkg;
    localparam int BYTE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int LSEL_W    = $clog2(NUM_LANES);
    localparam int WORD_W    = BYTE_W * NUM_LANES;

    typedef logic [LSEL_W-1:0] lane_t;
    typedef enum logic {ST_FILL, ST_HOLD} state_t;

    localparam logic TGT_EX  = 1'b1;
    localparam logic TGT_INS = 1'b0;
endpackage

// File: rtl/newbyte_sequencer_if.sv
// Byte-in / strobe-out / word-out bundle; slave is the sequencer, master the surrounding logic.
interface newbyte_sequencer_if;
    import newbyte_pkg::*;

    logic                byte_valid;
    logic [BYTE_W-1:0]   byte_data;
    logic                byte_is_ex;
    logic                pass;
    logic                byte_ready;
    logic                flush;
    logic                lane_strobe;
    lane_t               lane_sel;
    logic                byte_ex;
    logic                pass_out;
    logic [BYTE_W-1:0]   pass_data;
    logic                word_valid;
    logic                word_is_ex;
    logic [WORD_W-1:0]   word_data;
    logic                word_ready;

    modport master (
        output byte_valid, byte_data, byte_is_ex, pass, flush, word_ready,
        input  byte_ready, lane_strobe, lane_sel, byte_ex, pass_out, pass_data,
               word_valid, word_is_ex, word_data
    );

    modport slave (
        input  byte_valid, byte_data, byte_is_ex, pass, flush, word_ready,
        output byte_ready, lane_strobe, lane_sel, byte_ex, pass_out, pass_data,
               word_valid, word_is_ex, word_data
    );
endinterface

// File: rtl/newbyte_word_asm.sv
// Lane-indexed word register: writes one byte per cycle into the selected lane, clear wins over write.
// Write visible on the cycle after wr; no backpressure of its own.
module newbyte_word_asm
    import newbyte_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr,
    input  lane_t             wr_lane,
    input  logic [BYTE_W-1:0] wr_dat,
    output logic [WORD_W-1:0] word
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word <= '0;
        end else if (wr) begin
            for (int n = 0; n < NUM_LANES; n++) begin
                if (wr_lane == lane_t'(n)) word[n*BYTE_W +: BYTE_W] <= wr_dat;
            end
        end
    end
endmodule

// File: rtl/newbyte_sequencer.sv
// Byte-lane sequencer: strobes each accepted byte's lane one cycle after accept and presents the assembled word one cycle after the last lane.
// Stalls bytes (byte_ready=0) while a word is held; pass bytes and flush are always accepted.
module newbyte_sequencer
    import newbyte_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    newbyte_sequencer_if.slave bus
);
    localparam lane_t LAST_LANE = lane_t'(NUM_LANES - 1);

    state_t state, state_nxt;
    lane_t  lane, lane_nxt;
    logic   tgt, tgt_nxt;
    logic   acc, acc_pass, acc_lane;

    always_comb begin
        state_nxt      = state;
        lane_nxt       = lane;
        tgt_nxt        = tgt;
        bus.byte_ready = !rst && (bus.pass || (state == ST_FILL) || bus.flush);
        acc            = bus.byte_valid && bus.byte_ready;
        acc_pass       = acc && !bus.flush && bus.pass;
        // Without flush or pass, ready implies FILL, so a lane accept never collides with HOLD.
        acc_lane       = acc && !bus.flush && !bus.pass;
        bus.word_valid = (state == ST_HOLD);
        bus.word_is_ex = (state == ST_HOLD) && tgt;

        if (bus.flush) begin
            state_nxt = ST_FILL;
            lane_nxt  = '0;
        end else begin
            if (acc_lane) begin
                if (lane == '0) tgt_nxt = bus.byte_is_ex;
                if (lane == LAST_LANE) begin
                    lane_nxt  = '0;
                    state_nxt = ST_HOLD;
                end else begin
                    lane_nxt = lane_t'(lane + 1'b1);
                end
            end
            if (state == ST_HOLD && bus.word_ready) state_nxt = ST_FILL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_FILL;
            lane            <= '0;
            tgt             <= TGT_INS;
            bus.lane_strobe <= 1'b0;
            bus.lane_sel    <= '0;
            bus.byte_ex     <= 1'b0;
            bus.pass_out    <= 1'b0;
            bus.pass_data   <= '0;
        end else begin
            state           <= state_nxt;
            lane            <= lane_nxt;
            tgt             <= tgt_nxt;
            bus.lane_strobe <= acc_lane;
            bus.pass_out    <= acc_pass;
            if (acc_lane) begin
                bus.lane_sel <= lane;
                bus.byte_ex  <= tgt_nxt;
            end
            if (acc_pass) bus.pass_data <= bus.byte_data;
        end
    end

    newbyte_word_asm u_word_asm (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.flush),
        .wr      (acc_lane),
        .wr_lane (lane),
        .wr_dat  (bus.byte_data),
        .word    (bus.word_data)
    );
endmodule

// File: tb/tb_newbyte_sequencer.sv
// Scoreboarded bench: driver runs a word-level model and queues cycle-stamped expectations, monitor pops on DUT outputs.
module tb_newbyte_sequencer;
    import newbyte_pkg::*;

    typedef struct { int cyc; logic [1:0] lane; logic ex; } stb_t;
    typedef struct { int cyc; logic [7:0] d; } pas_t;
    typedef struct { int cyc; logic [31:0] d; logic ex; } wrd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;
    int   rst_stamp = -10;

    stb_t sq[$];
    pas_t pq[$];
    wrd_t wq[$];

    logic [7:0] part [4];
    int         m_lane;
    bit         m_hold;
    bit         m_tgt;

    newbyte_sequencer_if bus();

    newbyte_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    function automatic logic [31:0] model_word();
        logic [31:0] w;
        for (int i = 0; i < 4; i++) w[i*8 +: 8] = part[i];
        return w;
    endfunction

    task automatic model_reset();
        m_lane = 0;
        m_hold = 1'b0;
        m_tgt  = 1'b0;
        for (int i = 0; i < 4; i++) part[i] = 8'h00;
    endtask

    // One clock of stimulus; the model decides acceptance from its own view of the word state.
    task automatic drive(input bit v, input logic [7:0] d, input bit ex, input bit p,
                         input bit f, input bit wr, input bit r);
        bit acc;
        bit h0;
        @(negedge clk);
        rst            = r;
        bus.byte_valid = v;
        bus.byte_data  = d;
        bus.byte_is_ex = ex;
        bus.pass       = p;
        bus.flush      = f;
        bus.word_ready = wr;
        #1;
        if (chk_en) begin
            chk("byte_ready", bus.byte_ready, !r && (p || !m_hold || f));
            chk("word_valid", bus.word_valid, m_hold);
        end
        h0 = m_hold;
        if (r) begin
            model_reset();
            rst_stamp = cyc;
        end else if (f) begin
            m_lane = 0;
            m_hold = 1'b0;
            for (int i = 0; i < 4; i++) part[i] = 8'h00;
        end else begin
            acc = v && (p || !h0);
            if (acc && p) begin
                pq.push_back('{cyc, d});
            end else if (acc) begin
                if (m_lane == 0) m_tgt = ex;
                part[m_lane] = d;
                sq.push_back('{cyc, 2'(m_lane), m_tgt});
                if (m_lane == 3) begin
                    m_lane = 0;
                    m_hold = 1'b1;
                    wq.push_back('{cyc, model_word(), m_tgt});
                end else begin
                    m_lane++;
                end
            end
            if (h0 && wr) m_hold = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit ex, input bit wr);
        for (int i = 0; i < 4; i++) drive(1, w[i*8 +: 8], ex, 0, 0, wr, 0);
    endtask

    // Monitor: outputs produced by the edge after cycle c are seen here with cyc == c+1.
    initial begin
        stb_t s;
        pas_t pp;
        wrd_t w;
        logic [31:0] cur_d = '0;
        logic        cur_ex = 1'b0;
        bit          wv_prev = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!chk_en) continue;
            if (rst_stamp == cyc - 1) begin
                chk("rst_lane_strobe", bus.lane_strobe, 0);
                chk("rst_pass_out", bus.pass_out, 0);
                chk("rst_word_valid", bus.word_valid, 0);
                chk("rst_word_data", bus.word_data, 0);
                chk("rst_pass_data", bus.pass_data, 0);
                chk("rst_misc", {bus.lane_sel, bus.byte_ex, bus.word_is_ex}, 0);
            end
            chk("strobe_pass_exclusive", bus.lane_strobe && bus.pass_out, 0);

            while (sq.size() > 0 && sq[0].cyc < cyc - 1) begin
                chk("strobe_missing", 0, 1);
                void'(sq.pop_front());
            end
            if (bus.lane_strobe) begin
                if (sq.size() == 0 || sq[0].cyc != cyc - 1) chk("strobe_unexpected", 1, 0);
                else begin
                    s = sq.pop_front();
                    chk("lane_sel", bus.lane_sel, s.lane);
                    chk("byte_ex", bus.byte_ex, s.ex);
                end
            end

            while (pq.size() > 0 && pq[0].cyc < cyc - 1) begin
                chk("pass_missing", 0, 1);
                void'(pq.pop_front());
            end
            if (bus.pass_out) begin
                if (pq.size() == 0 || pq[0].cyc != cyc - 1) chk("pass_unexpected", 1, 0);
                else begin
                    pp = pq.pop_front();
                    chk("pass_data", bus.pass_data, pp.d);
                end
            end

            while (wq.size() > 0 && wq[0].cyc < cyc - 1) begin
                chk("word_missing", 0, 1);
                void'(wq.pop_front());
            end
            if (bus.word_valid && !wv_prev) begin
                if (wq.size() == 0 || wq[0].cyc != cyc - 1) chk("word_unexpected", 1, 0);
                else begin
                    w = wq.pop_front();
                    cur_d  = w.d;
                    cur_ex = w.ex;
                    chk("word_data", bus.word_data, w.d);
                    chk("word_is_ex", bus.word_is_ex, w.ex);
                end
            end else if (bus.word_valid) begin
                chk("word_data_stable", bus.word_data, cur_d);
                chk("word_is_ex_stable", bus.word_is_ex, cur_ex);
            end
            wv_prev = bus.word_valid;
        end
    end

    initial begin
        bus.byte_valid = 0; bus.byte_data = 0; bus.byte_is_ex = 0;
        bus.pass = 0; bus.flush = 0; bus.word_ready = 0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        chk_en = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 1);

        // EX word back-to-back with consumer always ready
        send_word(32'h44332211, TGT_EX, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);

        // INS word held for 5 cycles while a new byte is offered, then released
        send_word(32'hDDCCBBAA, TGT_INS, 0);
        for (int i = 0; i < 5; i++) drive(1, 8'hEE, 1, 0, 0, 0, 0);
        drive(1, 8'hEE, 1, 0, 0, 1, 0);
        drive(1, 8'hEE, 1, 0, 0, 0, 0);
        drive(1, 8'hEF, 1, 0, 0, 0, 0);
        drive(1, 8'hF0, 1, 0, 0, 0, 0);
        drive(1, 8'hF1, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);

        // pass byte splitting a word
        drive(1, 8'h01, 0, 0, 0, 1, 0);
        drive(1, 8'h02, 1, 0, 0, 1, 0);
        drive(1, 8'h5A, 1, 1, 0, 1, 0);
        drive(1, 8'h03, 1, 0, 0, 1, 0);
        drive(1, 8'h04, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);

        // flush after 2 lanes, then a clean EX word, then flush during HOLD
        drive(1, 8'hA0, 0, 0, 0, 0, 0);
        drive(1, 8'hA1, 0, 0, 0, 0, 0);
        drive(1, 8'hA2, 0, 1, 1, 1, 0);
        send_word(32'h13121110, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(1, 8'h77, 0, 0, 1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0);

        // reset mid-word, then a word starting again at lane 0
        drive(1, 8'hB0, 1, 0, 0, 0, 0);
        drive(1, 8'hB1, 1, 0, 0, 0, 0);
        drive(1, 8'hB2, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        send_word(32'h87654321, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 0);

        // byte_is_ex only sampled on lane 0
        drive(1, 8'hC0, 0, 0, 0, 1, 0);
        drive(1, 8'hC1, 1, 0, 0, 1, 0);
        drive(1, 8'hC2, 1, 0, 0, 1, 0);
        drive(1, 8'hC3, 1, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 8'hD0, 1, 0, 0, 1, 0);
        drive(1, 8'hD1, 0, 0, 0, 1, 0);
        drive(1, 8'hD2, 0, 0, 0, 1, 0);
        drive(1, 8'hD3, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(3, 0) != 0, 8'($urandom), 1'($urandom),
                  $urandom_range(4, 0) == 0, $urandom_range(24, 0) == 0,
                  $urandom_range(2, 0) != 0, $urandom_range(299, 0) == 0);
        end

        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, 1, 0);
        chk("queues_drained", sq.size() + pq.size() + wq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
